// File: rtl/gmm_param_sequencer.sv
// rtl/gmm_param_sequencer.sv - feeds feature vector and per-component GMM parameters to GMM_core
// and chains each returned score back as the next score_in, emitting one score per senone.
module gmm_param_sequencer #(
   parameter int          FEAT_SIZE   = 29,
   parameter int          COMP_SIZE   = 32,
   parameter int          SENONE_SIZE = 5120,
   parameter int          ADDR_W      = 24,
   parameter logic [31:0] LOG_ZERO    = 32'hFF7FFFFF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   frame_done,
   input  logic                   feat_valid,
   output logic                   feat_ready,
   input  logic [31:0]            feat_data,
   output logic                   mem_rd_en,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic [31:0]            mem_rdata,
   output logic                   core_valid,
   input  logic                   core_ready,
   output logic [32*FEAT_SIZE-1:0] core_feature,
   output logic [32*FEAT_SIZE-1:0] core_mean,
   output logic [32*FEAT_SIZE-1:0] core_prec,
   output logic [31:0]            core_weight,
   output logic [31:0]            core_factor,
   output logic [31:0]            core_score_in,
   input  logic                   score_valid,
   input  logic [31:0]            score_out,
   output logic                   sen_valid,
   input  logic                   sen_ready,
   output logic [12:0]            sen_id,
   output logic [31:0]            sen_score
);

   localparam int REC_WORDS = 2*FEAT_SIZE + 2;
   localparam int FW = (FEAT_SIZE > 1) ? $clog2(FEAT_SIZE) : 1;
   localparam int CW = (COMP_SIZE > 1) ? $clog2(COMP_SIZE) : 1;
   localparam int RW = $clog2(REC_WORDS);

   localparam logic [FW-1:0] FEAT_LAST = FW'(FEAT_SIZE - 1);
   localparam logic [CW-1:0] COMP_LAST = CW'(COMP_SIZE - 1);
   localparam logic [12:0]   SEN_LAST  = 13'(SENONE_SIZE - 1);
   localparam logic [RW-1:0] REC_LAST  = RW'(REC_WORDS - 1);
   localparam logic [RW-1:0] WEIGHT_IX = RW'(2*FEAT_SIZE);
   localparam logic [RW-1:0] FACTOR_IX = RW'(2*FEAT_SIZE + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_FEAT,
      S_FETCH,
      S_ISSUE,
      S_WAIT_SCORE,
      S_EMIT
   } state_t;

   state_t        state;
   logic [FW-1:0] feat_cnt;
   logic [CW-1:0] comp_cnt;
   logic [12:0]   sen_cnt;
   logic [RW-1:0] word_cnt;
   logic [RW-1:0] cap_idx;
   logic          cap_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         feat_ready    <= 1'b0;
         mem_rd_en     <= 1'b0;
         mem_addr      <= '0;
         core_valid    <= 1'b0;
         core_feature  <= '0;
         core_mean     <= '0;
         core_prec     <= '0;
         core_weight   <= '0;
         core_factor   <= '0;
         core_score_in <= LOG_ZERO;
         sen_valid     <= 1'b0;
         sen_id        <= '0;
         sen_score     <= '0;
         feat_cnt      <= '0;
         comp_cnt      <= '0;
         sen_cnt       <= '0;
         word_cnt      <= '0;
         cap_idx       <= '0;
         cap_pend      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state         <= S_LOAD_FEAT;
                  busy          <= 1'b1;
                  feat_ready    <= 1'b1;
                  feat_cnt      <= '0;
                  mem_addr      <= '0;
                  comp_cnt      <= '0;
                  sen_cnt       <= '0;
                  core_score_in <= LOG_ZERO;
               end
            end

            S_LOAD_FEAT: begin
               if (feat_valid) begin
                  for (int i = 0; i < FEAT_SIZE; i++) begin
                     if (feat_cnt == FW'(i)) core_feature[32*i +: 32] <= feat_data;
                  end
                  if (feat_cnt == FEAT_LAST) begin
                     feat_ready <= 1'b0;
                     state      <= S_FETCH;
                     mem_rd_en  <= 1'b1;
                     word_cnt   <= '0;
                     cap_pend   <= 1'b0;
                  end else begin
                     feat_cnt <= feat_cnt + 1'b1;
                  end
               end
            end

            // Reads issue back-to-back; each word lands one cycle later, so the
            // final capture happens in the cycle after mem_rd_en drops.
            S_FETCH: begin
               if (cap_pend) begin
                  for (int i = 0; i < FEAT_SIZE; i++) begin
                     if (cap_idx == RW'(i))             core_mean[32*i +: 32] <= mem_rdata;
                     if (cap_idx == RW'(FEAT_SIZE + i)) core_prec[32*i +: 32] <= mem_rdata;
                  end
                  if (cap_idx == WEIGHT_IX) core_weight <= mem_rdata;
                  if (cap_idx == FACTOR_IX) core_factor <= mem_rdata;
               end
               if (mem_rd_en) begin
                  mem_addr <= mem_addr + 1'b1;
                  cap_pend <= 1'b1;
                  cap_idx  <= word_cnt;
                  if (word_cnt == REC_LAST) mem_rd_en <= 1'b0;
                  else                      word_cnt  <= word_cnt + 1'b1;
               end else begin
                  cap_pend <= 1'b0;
                  if (cap_pend) begin
                     state      <= S_ISSUE;
                     core_valid <= 1'b1;
                  end
               end
            end

            S_ISSUE: begin
               if (core_ready) begin
                  core_valid <= 1'b0;
                  state      <= S_WAIT_SCORE;
               end
            end

            S_WAIT_SCORE: begin
               if (score_valid) begin
                  core_score_in <= score_out;
                  if (comp_cnt != COMP_LAST) begin
                     comp_cnt  <= comp_cnt + 1'b1;
                     state     <= S_FETCH;
                     mem_rd_en <= 1'b1;
                     word_cnt  <= '0;
                  end else begin
                     sen_score <= score_out;
                     sen_id    <= sen_cnt;
                     sen_valid <= 1'b1;
                     state     <= S_EMIT;
                  end
               end
            end

            S_EMIT: begin
               if (sen_ready) begin
                  sen_valid     <= 1'b0;
                  comp_cnt      <= '0;
                  core_score_in <= LOG_ZERO;
                  if (sen_cnt != SEN_LAST) begin
                     sen_cnt   <= sen_cnt + 1'b1;
                     state     <= S_FETCH;
                     mem_rd_en <= 1'b1;
                     word_cnt  <= '0;
                  end else begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     mem_addr   <= '0;
                     state      <= S_IDLE;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gmm_param_sequencer.sv
// tb/tb_gmm_param_sequencer.sv - randomized self-checking bench for gmm_param_sequencer
// against a record-address / score-chain reference model.
module tb_gmm_param_sequencer;

   localparam int          F   = 2;
   localparam int          C   = 2;
   localparam int          S   = 2;
   localparam int          AW  = 24;
   localparam int          REC = 2*F + 2;
   localparam logic [31:0] LZ  = 32'hFF7FFFFF;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start, busy, frame_done;
   logic            feat_valid, feat_ready;
   logic [31:0]     feat_data;
   logic            mem_rd_en;
   logic [AW-1:0]   mem_addr;
   logic [31:0]     mem_rdata;
   logic            core_valid, core_ready;
   logic [32*F-1:0] core_feature, core_mean, core_prec;
   logic [31:0]     core_weight, core_factor, core_score_in;
   logic            score_valid;
   logic [31:0]     score_out;
   logic            sen_valid, sen_ready;
   logic [12:0]     sen_id;
   logic [31:0]     sen_score;

   gmm_param_sequencer #(
      .FEAT_SIZE(F), .COMP_SIZE(C), .SENONE_SIZE(S), .ADDR_W(AW), .LOG_ZERO(LZ)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
      .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .core_valid(core_valid), .core_ready(core_ready),
      .core_feature(core_feature), .core_mean(core_mean), .core_prec(core_prec),
      .core_weight(core_weight), .core_factor(core_factor), .core_score_in(core_score_in),
      .score_valid(score_valid), .score_out(score_out),
      .sen_valid(sen_valid), .sen_ready(sen_ready), .sen_id(sen_id), .sen_score(sen_score)
   );

   always #5 clk = ~clk;

   // Parameter memory: word n holds n; data is garbage except the cycle after a read.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= 32'(mem_addr);
      else           mem_rdata <= $urandom;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Read monitor: addresses must run 0,1,2.. within a frame, never while a bus is offered.
   int rd_total = 0, rd_in_frame = 0, addr_err = 0, fd_total = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         rd_in_frame = 0;
      end else begin
         if (mem_rd_en) begin
            if (mem_addr !== AW'(rd_in_frame) || core_valid || sen_valid) addr_err++;
            rd_in_frame++;
            rd_total++;
         end
         if (frame_done) begin
            fd_total++;
            rd_in_frame = 0;
         end
      end
   end

   logic [31:0] feat [F];
   logic [31:0] exp_si;

   task automatic chk_bus(input int base);
      logic [63:0] ef, em, ep;
      for (int i = 0; i < F; i++) begin
         ef[32*i +: 32] = feat[i];
         em[32*i +: 32] = 32'(base + i);
         ep[32*i +: 32] = 32'(base + F + i);
      end
      chk("core_feature", core_feature, ef);
      chk("core_mean", core_mean, em);
      chk("core_prec", core_prec, ep);
      chk("core_weight", core_weight, 64'(base + 2*F));
      chk("core_factor", core_factor, 64'(base + 2*F + 1));
      chk("core_score_in", core_score_in, exp_si);
      chk("core_valid_hold", core_valid, 1);
   endtask

   task automatic start_and_load(input bit directed);
      for (int k = 0; k < F; k++) feat[k] = directed ? 32'(5 + k) : $urandom;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int k = 0; k < F; k++) begin
         if (!directed) repeat ($urandom_range(0, 2)) @(negedge clk);
         chk("feat_ready", feat_ready, 1);
         feat_valid = 1'b1;
         feat_data  = feat[k];
         @(negedge clk);
         feat_valid = 1'b0;
      end
      chk("feat_ready_low", feat_ready, 0);
      exp_si = LZ;
   endtask

   task automatic run_frame(input bit directed);
      int n, base, stall, rd0, fd0;
      logic [31:0] sc;
      rd0 = rd_total;
      fd0 = fd_total;
      start_and_load(directed);
      for (int s = 0; s < S; s++) begin
         for (int c = 0; c < C; c++) begin
            n = 0;
            while (!core_valid && n < 100) begin
               if (!directed) begin
                  start       = ($urandom % 4 == 0);
                  score_valid = ($urandom % 4 == 0);
                  score_out   = $urandom;
                  feat_valid  = ($urandom % 4 == 0);
                  feat_data   = $urandom;
               end
               @(negedge clk);
               n++;
            end
            start = 1'b0; score_valid = 1'b0; feat_valid = 1'b0;
            chk("core_valid_timeout", core_valid, 1);
            base  = (s*C + c) * REC;
            stall = directed ? ((s == 0 && c == 0) ? 10 : 0) : $urandom_range(0, 3);
            for (int t = 0; t <= stall; t++) begin
               chk_bus(base);
               if (t < stall) begin
                  if (!directed) score_valid = $urandom % 2;
                  score_out = $urandom;
                  @(negedge clk);
                  score_valid = 1'b0;
               end
            end
            core_ready = 1'b1;
            @(negedge clk);
            core_ready = 1'b0;
            chk("core_valid_drop", core_valid, 0);
            if (!directed) repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("score_in_waiting", core_score_in, exp_si);
            sc = directed ? (32'h11 * 32'(c + 1) + 32'h100 * 32'(s)) : $urandom;
            score_valid = 1'b1;
            score_out   = sc;
            @(negedge clk);
            score_valid = 1'b0;
            chk("score_chain", core_score_in, sc);
            exp_si = sc;
            if (c == C - 1) begin
               stall = directed ? ((s == 0) ? 5 : 0) : $urandom_range(0, 3);
               for (int t = 0; t <= stall; t++) begin
                  chk("sen_valid", sen_valid, 1);
                  chk("sen_id", sen_id, 64'(s));
                  chk("sen_score", sen_score, sc);
                  if (t < stall) @(negedge clk);
               end
               sen_ready = 1'b1;
               @(negedge clk);
               sen_ready = 1'b0;
               chk("sen_valid_drop", sen_valid, 0);
               chk("score_in_restart", core_score_in, LZ);
               exp_si = LZ;
               if (s == S - 1) begin
                  chk("frame_done_pulse", frame_done, 1);
                  chk("busy_fall", busy, 0);
                  chk("mem_addr_idle", mem_addr, 0);
                  @(negedge clk);
                  chk("frame_done_once", frame_done, 0);
               end
            end
         end
      end
      chk("reads_per_frame", 64'(rd_total - rd0), 64'(S*C*REC));
      chk("frame_done_count", 64'(fd_total - fd0), 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_feat_ready", feat_ready, 0);
      chk("rst_mem_rd_en", mem_rd_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_core_valid", core_valid, 0);
      chk("rst_core_feature", core_feature, 0);
      chk("rst_core_mean", core_mean, 0);
      chk("rst_core_prec", core_prec, 0);
      chk("rst_core_weight", core_weight, 0);
      chk("rst_core_factor", core_factor, 0);
      chk("rst_core_score_in", core_score_in, LZ);
      chk("rst_sen_valid", sen_valid, 0);
      chk("rst_sen_id", sen_id, 0);
      chk("rst_sen_score", sen_score, 0);
   endtask

   initial begin
      int n, fd0;
      rst_n = 1'b0; start = 1'b0; feat_valid = 1'b0; feat_data = '0;
      core_ready = 1'b0; score_valid = 1'b0; score_out = '0; sen_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);

      run_frame(1'b1);
      repeat (4) run_frame(1'b0);

      // Abort mid-FETCH: reset takes effect without a clock and no frame_done follows.
      fd0 = fd_total;
      start_and_load(1'b0);
      n = 0;
      while (!mem_rd_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("fetch_seen", mem_rd_en, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs();
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_no_frame_done", 64'(fd_total - fd0), 0);
      chk("abort_idle", busy, 0);

      run_frame(1'b0);
      chk("addr_sequence", 64'(addr_err), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
